// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction / data) arbiter onto a single SRAM-style bus.
// Ties between the ports are broken round-robin on the last accepted source.
// A stalled bus request is held on the same source until the bus accepts it.
// A source-order FIFO routes the in-order bus responses back to their issuers.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ARB_OPEN   | no stalled request; grant chosen from i_req/d_req this cycle
// ARB_HOLD_I | instruction request stalled on the bus; keep granting INST
// ARB_HOLD_D | data request stalled on the bus; keep granting DATA
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  // instruction port
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         i_addr_ok,
  output logic [DATA_W-1:0]            i_rdata,
  output logic                         i_data_ok,
  // data port
  input  logic                         d_req,
  input  logic                         d_wr,
  input  logic [DATA_W/8-1:0]          d_wstrb,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         d_addr_ok,
  output logic [DATA_W-1:0]            d_rdata,
  output logic                         d_data_ok,
  // memory bus
  output logic                         m_req,
  output logic                         m_wr,
  output logic [DATA_W/8-1:0]          m_wstrb,
  output logic [ADDR_W-1:0]            m_addr,
  output logic [DATA_W-1:0]            m_wdata,
  input  logic                         m_addr_ok,
  input  logic [DATA_W-1:0]            m_rdata,
  input  logic                         m_data_ok,
  // status
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         proto_err
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  // source encoding shared by last_src and the FIFO entries
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_OPEN   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_t;

  arb_state_t      state_q, state_d;
  logic            last_src_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            src_fifo_q [MAX_OUT];
  logic            perr_q;

  logic            issue_en;
  logic            grant_src;
  logic            grant_req;
  logic            accept;
  logic            resp_valid;
  logic            stray_resp;
  logic            head_src;

  // issue gating uses the registered count only, so a same-cycle response
  // never opens a slot early
  assign issue_en   = (count_q < CW'(MAX_OUT));
  assign head_src   = src_fifo_q[rd_ptr_q];
  assign resp_valid = m_data_ok && (count_q != '0);
  assign stray_resp = m_data_ok && (count_q == '0);
  assign accept     = m_req && m_addr_ok;

  // grant selection and bus mux; a held state pins the grant to its source
  always_comb begin
    grant_src = SRC_INST;
    case (state_q)
      ARB_HOLD_I: grant_src = SRC_INST;
      ARB_HOLD_D: grant_src = SRC_DATA;
      default: begin
        if (i_req && d_req) begin
          grant_src = ~last_src_q;
        end else if (d_req) begin
          grant_src = SRC_DATA;
        end else begin
          grant_src = SRC_INST;
        end
      end
    endcase

    grant_req = (grant_src == SRC_DATA) ? d_req : i_req;
    m_req     = issue_en && grant_req;

    if (grant_src == SRC_DATA) begin
      m_wr    = d_wr;
      m_wstrb = d_wstrb;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else begin
      m_wr    = 1'b0;
      m_wstrb = '0;
      m_addr  = i_addr;
      m_wdata = '0;
    end
  end

  // next state: hold the grant while the bus stalls, release on accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_OPEN: begin
        if (m_req && !m_addr_ok) begin
          state_d = (grant_src == SRC_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
        end
      end
      ARB_HOLD_I, ARB_HOLD_D: begin
        // a dropped request also releases the hold so the arbiter cannot wedge
        if (!m_req || m_addr_ok) begin
          state_d = ARB_OPEN;
        end
      end
      default: state_d = ARB_OPEN;
    endcase
  end

  // port handshakes and response routing
  always_comb begin
    i_addr_ok = accept && (grant_src == SRC_INST);
    d_addr_ok = accept && (grant_src == SRC_DATA);
    i_data_ok = resp_valid && (head_src == SRC_INST);
    d_data_ok = resp_valid && (head_src == SRC_DATA);
    i_rdata   = m_rdata;
    d_rdata   = m_rdata;
  end

  // arbitration state, round-robin history and sticky protocol error
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_OPEN;
      last_src_q <= SRC_INST;
      perr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_src_q <= grant_src;
      end
      if (stray_resp) begin
        perr_q <= 1'b1;
      end
    end
  end

  // outstanding counter: accept and response in one cycle cancel out
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      case ({accept, resp_valid})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // source-order FIFO pointers, wrapping modulo MAX_OUT
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (resp_valid) begin
        rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  // FIFO storage; entries beyond the pointers are don't-care so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      src_fifo_q[wr_ptr_q] <= grant_src;
    end
  end

  assign outstanding = count_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a table of cycle vectors from reset,
// hand-written multi-cycle sequences, and a randomized run against a queue model.
module tb_mem_bus_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 2;
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic                clk = 1'b0;
  logic                reset;
  logic                i_req;
  logic [ADDR_W-1:0]   i_addr;
  logic                i_addr_ok;
  logic [DATA_W-1:0]   i_rdata;
  logic                i_data_ok;
  logic                d_req;
  logic                d_wr;
  logic [DATA_W/8-1:0] d_wstrb;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_addr_ok;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_data_ok;
  logic                m_req;
  logic                m_wr;
  logic [DATA_W/8-1:0] m_wstrb;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic                m_addr_ok;
  logic [DATA_W-1:0]   m_rdata;
  logic                m_data_ok;
  logic [CW-1:0]       outstanding;
  logic                proto_err;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_rdata(i_rdata), .i_data_ok(i_data_ok),
    .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_rdata(d_rdata),
    .d_data_ok(d_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_rdata(m_rdata),
    .m_data_ok(m_data_ok),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0;
    d_req = 0; d_wr = 0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    m_addr_ok = 0; m_rdata = '0; m_data_ok = 0;
  endtask

  // leaves the bench 1 time unit after a rising edge with reset released
  task automatic do_reset();
    reset = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        i_req, d_req, aok, dok;
    logic [31:0] rdata;
    logic        e_mreq, e_iaok, e_daok, e_idok, e_ddok;
    logic [1:0]  e_out;
    logic        e_perr;
  } vec_t;

  vec_t tbl[12];

  // reference model state for the random run
  bit   src_q[$];
  bit   m_last;
  bit   m_pend_v, m_pend_s;
  bit   m_perr;

  initial begin
    bit g, issue, ereq, acc, resp, acc_i_prev, acc_d_prev;
    logic [ADDR_W-1:0] e_addr;

    reset = 1;
    idle_inputs();

    // ---------------- table-driven sequence from reset ----------------
    // cols: i d aok dok rdata | m_req i_aok d_aok i_dok d_dok out perr
    tbl[0]  = '{1,1,1,0,32'h0000_0000, 1,0,1,0,0,2'd0,0};
    tbl[1]  = '{1,1,1,0,32'h0000_0000, 1,1,0,0,0,2'd1,0};
    tbl[2]  = '{1,1,1,0,32'h0000_0000, 0,0,0,0,0,2'd2,0};
    tbl[3]  = '{1,1,1,1,32'h1111_0001, 0,0,0,0,1,2'd2,0};
    tbl[4]  = '{1,1,1,1,32'h2222_0002, 1,0,1,1,0,2'd1,0};
    tbl[5]  = '{0,1,0,0,32'h0000_0000, 1,0,0,0,0,2'd1,0};
    tbl[6]  = '{1,1,1,1,32'h3333_0003, 1,0,1,0,1,2'd1,0};
    tbl[7]  = '{1,0,1,0,32'h0000_0000, 1,1,0,0,0,2'd1,0};
    tbl[8]  = '{0,0,0,1,32'h4444_0004, 0,0,0,0,1,2'd2,0};
    tbl[9]  = '{0,0,0,1,32'h5555_0005, 0,0,0,1,0,2'd1,0};
    tbl[10] = '{0,0,0,1,32'h6666_0006, 0,0,0,0,0,2'd0,0};
    tbl[11] = '{0,0,0,0,32'h0000_0000, 0,0,0,0,0,2'd0,1};

    do_reset();
    check("reset_outstanding", outstanding, 0);
    check("reset_proto_err", proto_err, 0);
    check("reset_m_req", m_req, 0);
    i_addr = 32'h100; d_addr = 32'h200;
    for (int r = 0; r < 12; r++) begin
      i_req = tbl[r].i_req; d_req = tbl[r].d_req;
      m_addr_ok = tbl[r].aok; m_data_ok = tbl[r].dok; m_rdata = tbl[r].rdata;
      #4;
      check($sformatf("tbl%0d_m_req", r), m_req, tbl[r].e_mreq);
      check($sformatf("tbl%0d_i_addr_ok", r), i_addr_ok, tbl[r].e_iaok);
      check($sformatf("tbl%0d_d_addr_ok", r), d_addr_ok, tbl[r].e_daok);
      check($sformatf("tbl%0d_i_data_ok", r), i_data_ok, tbl[r].e_idok);
      check($sformatf("tbl%0d_d_data_ok", r), d_data_ok, tbl[r].e_ddok);
      check($sformatf("tbl%0d_outstanding", r), outstanding, tbl[r].e_out);
      check($sformatf("tbl%0d_proto_err", r), proto_err, tbl[r].e_perr);
      check($sformatf("tbl%0d_i_rdata", r), i_rdata, tbl[r].rdata);
      check($sformatf("tbl%0d_d_rdata", r), d_rdata, tbl[r].rdata);
      next_cycle();
    end
    // sticky error survives idle cycles, then reset clears it
    idle_inputs();
    next_cycle();
    check("perr_sticky", proto_err, 1);
    do_reset();
    check("perr_cleared_by_reset", proto_err, 0);

    // ---------------- single instruction read ----------------
    i_req = 1; i_addr = 32'h100; m_addr_ok = 1;
    #4;
    check("s1_i_addr_ok", i_addr_ok, 1);
    check("s1_m_addr", m_addr, 32'h100);
    check("s1_m_wr", m_wr, 0);
    next_cycle();
    i_req = 0; m_addr_ok = 0;
    #4;
    check("s1_outstanding", outstanding, 1);
    next_cycle();
    m_data_ok = 1; m_rdata = 32'hDEADBEEF;
    #4;
    check("s1_i_data_ok", i_data_ok, 1);
    check("s1_d_data_ok", d_data_ok, 0);
    check("s1_i_rdata", i_rdata, 32'hDEADBEEF);
    next_cycle();
    m_data_ok = 0;
    #4;
    check("s1_outstanding_after", outstanding, 0);
    check("s1_no_perr", proto_err, 0);

    // ---------------- stalled write holds the bus ----------------
    do_reset();
    d_req = 1; d_wr = 1; d_wstrb = 4'hF; d_addr = 32'h200; d_wdata = 32'hCAFE_F00D;
    i_addr = 32'h104; m_addr_ok = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) i_req = 1;
      #4;
      check($sformatf("s3_stall%0d_m_addr", c), m_addr, 32'h200);
      check($sformatf("s3_stall%0d_m_wr", c), m_wr, 1);
      check($sformatf("s3_stall%0d_m_req", c), m_req, 1);
      check($sformatf("s3_stall%0d_addr_oks", c), {i_addr_ok, d_addr_ok}, 2'b00);
      next_cycle();
    end
    m_addr_ok = 1;
    #4;
    check("s3_accept_d_addr_ok", d_addr_ok, 1);
    check("s3_accept_m_addr", m_addr, 32'h200);
    check("s3_accept_m_wdata", m_wdata, 32'hCAFE_F00D);
    check("s3_accept_m_wstrb", m_wstrb, 4'hF);
    next_cycle();
    d_req = 0;
    #4;
    check("s3_inst_i_addr_ok", i_addr_ok, 1);
    check("s3_inst_m_addr", m_addr, 32'h104);
    check("s3_inst_m_wr", m_wr, 0);
    check("s3_inst_m_wstrb", m_wstrb, 0);
    next_cycle();
    i_req = 0; m_addr_ok = 0;
    m_data_ok = 1;
    #4;
    check("s3_write_done", {i_data_ok, d_data_ok}, 2'b01);
    next_cycle();
    #4;
    check("s3_inst_resp", {i_data_ok, d_data_ok}, 2'b10);
    next_cycle();
    m_data_ok = 0;

    // ---------------- randomized run against queue model ----------------
    do_reset();
    src_q.delete();
    m_last = 0; m_pend_v = 0; m_pend_s = 0; m_perr = 0;
    acc_i_prev = 0; acc_d_prev = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_req || acc_i_prev) begin
        i_req = ($urandom_range(0, 1) == 1);
        i_addr = $urandom;
      end
      if (!d_req || acc_d_prev) begin
        d_req = ($urandom_range(0, 1) == 1);
        d_wr = ($urandom_range(0, 1) == 1);
        d_wstrb = 4'($urandom);
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      m_addr_ok = ($urandom_range(0, 3) != 0);
      m_rdata = $urandom;
      if (src_q.size() > 0) m_data_ok = ($urandom_range(0, 1) == 1);
      else m_data_ok = ($urandom_range(0, 99) == 0);

      // expected behaviour from the arbitration rules
      issue = (src_q.size() < MAX_OUT);
      if (m_pend_v) g = m_pend_s;
      else if (i_req && d_req) g = !m_last;
      else g = d_req;
      ereq = issue && (g ? d_req : i_req);
      acc = ereq && m_addr_ok;
      resp = m_data_ok && (src_q.size() > 0);
      e_addr = g ? d_addr : i_addr;

      #4;
      check("rnd_m_req", m_req, ereq);
      check("rnd_addr_oks", {i_addr_ok, d_addr_ok}, {acc && !g, acc && g});
      check("rnd_data_oks", {i_data_ok, d_data_ok},
            {resp && (src_q[0] == 0), resp && (src_q[0] == 1)});
      check("rnd_outstanding", outstanding, src_q.size());
      check("rnd_proto_err", proto_err, m_perr);
      if (ereq) begin
        check("rnd_m_addr", m_addr, e_addr);
        check("rnd_m_wr_wstrb", {m_wr, m_wstrb}, g ? {d_wr, d_wstrb} : 5'b0);
        if (g) check("rnd_m_wdata", m_wdata, d_wdata);
      end
      check("rnd_rdata", {i_rdata, d_rdata}, {m_rdata, m_rdata});

      next_cycle();
      if (m_data_ok && src_q.size() == 0) m_perr = 1;
      if (resp) void'(src_q.pop_front());
      if (acc) begin
        src_q.push_back(g);
        m_last = g;
      end
      m_pend_v = ereq && !m_addr_ok;
      m_pend_s = g;
      acc_i_prev = acc && !g;
      acc_d_prev = acc && g;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
